// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - N-channel memory-mapped timer/counter with sticky expiry and level irqs
// Channel c occupies word addresses c*8..c*8+4; IRQ_PENDING sits at NUM_CH*8.
module multi_timer #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]     irq,
  output logic                  irq_any
);

  localparam int CW = ADDR_WIDTH - 3;
  localparam logic [ADDR_WIDTH-1:0] IRQ_ADDR = ADDR_WIDTH'(NUM_CH * 8);
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_PERIOD = 3'd2;
  localparam logic [2:0] OFF_COUNT  = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  logic [CW-1:0] sel_ch;
  logic [2:0]    sel_off;
  logic          in_chan;

  assign sel_ch  = addr[ADDR_WIDTH-1:3];
  assign sel_off = addr[2:0];
  assign in_chan = (addr < IRQ_ADDR);

  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] irq_en_q, irq_en_d;
  logic [NUM_CH-1:0] oneshot_q, oneshot_d;
  logic [NUM_CH-1:0] expired_q, expired_d;
  logic [DATA_WIDTH-1:0] presc_q  [NUM_CH];
  logic [DATA_WIDTH-1:0] presc_d  [NUM_CH];
  logic [DATA_WIDTH-1:0] period_q [NUM_CH];
  logic [DATA_WIDTH-1:0] period_d [NUM_CH];
  logic [DATA_WIDTH-1:0] count_q  [NUM_CH];
  logic [DATA_WIDTH-1:0] count_d  [NUM_CH];
  logic [DATA_WIDTH-1:0] pcount_q [NUM_CH];
  logic [DATA_WIDTH-1:0] pcount_d [NUM_CH];

  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] cnt_wr;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] expire;

  always_comb begin
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    oneshot_d = oneshot_q;
    expired_d = expired_q;
    presc_d   = presc_q;
    period_d  = period_q;
    count_d   = count_q;
    pcount_d  = pcount_q;
    wr_hit    = '0;
    cnt_wr    = '0;
    tick      = '0;
    expire    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit[c] = write_enable && in_chan && (sel_ch == CW'(c));
      cnt_wr[c] = wr_hit[c] && (sel_off == OFF_COUNT);
      tick[c]   = en_q[c] && (pcount_q[c] >= presc_q[c]);
      // A software COUNTER load suppresses any expiry on the same edge.
      expire[c] = tick[c] && (period_q[c] != '0) && (count_q[c] >= period_q[c]) && !cnt_wr[c];

      if (en_q[c]) pcount_d[c] = tick[c] ? '0 : pcount_q[c] + ONE;
      if (tick[c]) count_d[c] = expire[c] ? '0 : count_q[c] + ONE;

      // Ordering below gives: expiry beats W1C, CTRL write beats one-shot auto-clear.
      if (wr_hit[c] && (sel_off == OFF_STATUS) && data_in[0]) expired_d[c] = 1'b0;
      if (expire[c]) begin
        expired_d[c] = 1'b1;
        if (oneshot_q[c]) en_d[c] = 1'b0;
      end

      if (wr_hit[c]) begin
        case (sel_off)
          OFF_CTRL:   {oneshot_d[c], irq_en_d[c], en_d[c]} = data_in[2:0];
          OFF_PRESC:  presc_d[c]  = data_in;
          OFF_PERIOD: period_d[c] = data_in;
          OFF_COUNT: begin
            count_d[c]  = data_in;
            pcount_d[c] = '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q      <= '0;
      irq_en_q  <= '0;
      oneshot_q <= '0;
      expired_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        presc_q[c]  <= '0;
        period_q[c] <= '0;
        count_q[c]  <= '0;
        pcount_q[c] <= '0;
      end
    end else begin
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      oneshot_q <= oneshot_d;
      expired_q <= expired_d;
      presc_q   <= presc_d;
      period_q  <= period_d;
      count_q   <= count_d;
      pcount_q  <= pcount_d;
    end
  end

  assign irq     = expired_q & irq_en_q;
  assign irq_any = |irq;

  always_comb begin
    data_out = '0;
    if (addr == IRQ_ADDR) data_out = DATA_WIDTH'(irq);
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_chan && (sel_ch == CW'(c))) begin
        case (sel_off)
          OFF_CTRL:   data_out = DATA_WIDTH'({oneshot_q[c], irq_en_q[c], en_q[c]});
          OFF_PRESC:  data_out = presc_q[c];
          OFF_PERIOD: data_out = period_q[c];
          OFF_COUNT:  data_out = count_q[c];
          OFF_STATUS: data_out = DATA_WIDTH'(expired_q[c]);
          default:    data_out = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - scoreboard-driven self-checking bench for multi_timer
`timescale 1ns/1ps
module tb_multi_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  addr;
  logic [31:0] data_in;
  logic        write_enable;
  logic [31:0] data_out;
  logic [3:0]  irq;
  logic        irq_any;

  multi_timer #(.NUM_CH(4), .DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
    .write_enable(write_enable), .data_out(data_out),
    .irq(irq), .irq_any(irq_any)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    sb_q.push_back('{tag, val});
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
    else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string tag);
    sb_push(tag, exp);
    addr = a;
    #1;
    sb_pop(data_out);
  endtask

  task automatic chk_irq(input logic [3:0] exp, input string tag);
    sb_push(tag, {28'b0, exp});
    sb_pop({28'b0, irq});
  endtask

  task automatic chk_any(input logic exp, input string tag);
    sb_push(tag, {31'b0, exp});
    sb_pop({31'b0, irq_any});
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    addr = a;
    data_in = d;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Count after k enabled edges from a cleared channel.
  function automatic logic [31:0] cnt_model(input int k, input int presc, input int period);
    int t;
    t = k / (presc + 1);
    return (period == 0) ? 32'(t) : 32'(t % (period + 1));
  endfunction

  int map_addrs[8] = '{5, 6, 7, 13, 32, 33, 40, 63};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; addr = '0; data_in = '0; write_enable = 1'b0;
    step(2);
    rst = 1'b0;
    rd(0, 0, "rst_ctrl0"); rd(3, 0, "rst_cnt0"); rd(32, 0, "rst_pend");
    chk_irq(4'h0, "rst_irq"); chk_any(1'b0, "rst_any");

    // periodic channel 0
    wr(1, 1); wr(2, 3); wr(0, 3);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) step(1);
      rd(3, cnt_model(k, 1, 3), "per_cnt");
      if (k == 7) chk_irq(4'h0, "per_irq_early");
    end
    chk_irq(4'h1, "per_irq"); chk_any(1'b1, "per_any");
    rd(4, 1, "per_status"); rd(32, 1, "per_pend");
    wr(4, 1);
    chk_irq(4'h0, "per_w1c");
    step(6); chk_irq(4'h0, "per_irq2_early");
    step(1); chk_irq(4'h1, "per_irq2");
    wr(0, 0); wr(4, 1);
    chk_any(1'b0, "per_cleanup_any");

    // one-shot channel 1
    wr(10, 5); wr(8, 7);
    step(5); rd(12, 0, "os_pre");
    step(1); rd(12, 1, "os_exp"); rd(8, 6, "os_ctrl"); chk_irq(4'h2, "os_irq");
    step(20); rd(11, 0, "os_hold_cnt"); chk_irq(4'h2, "os_irq_hold"); chk_any(1'b1, "os_any");
    wr(12, 1); chk_irq(4'h0, "os_clr"); chk_any(1'b0, "os_clr_any");

    // free-run and wrap, channel 2
    wr(19, 32'hFFFF_FFFE); wr(16, 1);
    rd(19, 32'hFFFF_FFFE, "fr_start");
    step(1); rd(19, 32'hFFFF_FFFF, "fr_max");
    step(1); rd(19, 32'h0, "fr_wrap");
    step(1); rd(19, 32'h1, "fr_one");
    rd(20, 0, "fr_no_exp");
    wr(19, 10); rd(19, 10, "col_cnt_wr");
    step(1); rd(19, 11, "col_cnt_next");
    wr(16, 0);

    // W1C on the expiry edge, channel 1
    wr(10, 2); wr(8, 7); step(2);
    wr(12, 1); rd(12, 1, "col_w1c"); rd(8, 6, "col_w1c_ctrl");
    wr(12, 1); rd(12, 0, "col_w1c_clr");

    // CTRL write on the one-shot expiry edge
    wr(8, 7); step(2);
    wr(8, 5); rd(8, 5, "col_ctrl"); rd(12, 1, "col_ctrl_st");
    wr(8, 0); wr(12, 1);

    // IRQ_EN gating and enable freeze, channel 3
    wr(26, 1); wr(24, 1); step(2);
    rd(28, 1, "gate_st"); chk_irq(4'h0, "gate_irq_off");
    wr(24, 3); chk_irq(4'h8, "gate_irq_on"); rd(32, 8, "gate_pend"); chk_any(1'b1, "gate_any");
    wr(24, 0); wr(28, 1); chk_irq(4'h0, "gate_clr");
    wr(27, 0); wr(26, 100); wr(24, 1); step(5);
    wr(24, 0); step(10); rd(27, 6, "frz_hold");
    wr(24, 1); step(3); rd(27, 9, "frz_resume");
    wr(24, 0);

    // asynchronous reset mid-count
    wr(1, 1); wr(2, 3); wr(0, 3); step(9);
    chk_irq(4'h1, "pre_rst_irq");
    #2 rst = 1'b1;
    #1;
    chk_irq(4'h0, "arst_irq"); chk_any(1'b0, "arst_any");
    rd(0, 0, "arst_ctrl0"); rd(1, 0, "arst_presc0"); rd(2, 0, "arst_period0");
    rd(3, 0, "arst_cnt0"); rd(4, 0, "arst_st0");
    @(negedge clk);
    rst = 1'b0;
    wr(1, 2); wr(0, 1);
    step(2); rd(3, 0, "rst_first_pre");
    step(1); rd(3, 1, "rst_first_tick");
    wr(0, 0);

    // unmapped reads and writes
    wr(2, 32'h55);
    foreach (map_addrs[i]) begin
      wr(6'(map_addrs[i]), 32'hFFFF_FFFF);
      rd(6'(map_addrs[i]), 0, "map_rd");
    end
    rd(2, 32'h55, "map_period0"); rd(1, 2, "map_presc0"); rd(3, 1, "map_cnt0");
    rd(9, 0, "map_presc1"); rd(0, 0, "map_ctrl0"); chk_irq(4'h0, "map_irq");

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
